rv32m_mdu: RTL and testbench

//  Iterative RV32M multiply/divide unit in the execute stage, fed directly by register-file rd1/rd2.

---
 rtl/rv32m_mdu.sv | 248 ++++++++++++++++++++++++
 tb/tb_rv32m_mdu.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_mdu.sv
// ---------------------------------------------------------------------------
// rv32m_mdu
//   Iterative RV32M multiply/divide unit for the execute stage. One op is
//   accepted through a start/ready handshake, operands are captured at accept
//   time, and the result appears on `result` with a one-cycle `done` pulse.
//
//   Multiply: shift-add over magnitudes, one multiplier bit per cycle, 64-bit
//             accumulator; sign fixed up at the end.
//   Divide:   restoring, one quotient bit per cycle; quotient/remainder signs
//             fixed up at the end. Divide-by-zero and INT_MIN/-1 bypass the
//             iteration entirely.
//
//   Build option: define MDU_FAST_MUL_EN to replace the iterative multiply by
//   a single-cycle multiply at accept (divide path unchanged). Results are
//   identical in both builds; only multiply latency differs.
//
// Ports
//   clk     in   clock, rising edge
//   rstn    in   asynchronous active-low reset
//   start   in   op request, sampled only while ready=1
//   funct3  in   RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1/rs2 in   operands A/B
//   flush   in   synchronous abort; next edge returns to idle without done
//   ready   out  unit idle, will accept start this cycle
//   busy    out  ~ready
//   done    out  one-cycle pulse, result valid
//   result  out  last result, held until the next op completes
// ---------------------------------------------------------------------------
module rv32m_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int               CNT_W    = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        f3_q,     f3_d;
    logic              neg_q,    neg_d;     // negate product / quotient in FIX
    logic              rneg_q,   rneg_d;    // negate remainder in FIX
    logic [2*XLEN-1:0] acc_q,    acc_d;     // mul: {hi, multiplier}; div: {rem, quot}
    logic [XLEN-1:0]   b_q,      b_d;       // |multiplicand| or |divisor|
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q,   done_d;
    logic              ready_q,  ready_d;

    // ---------------- operand decode at accept ----------------
    logic            is_div;
    logic            signed_a;
    logic            signed_b;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            div_ovf;

    assign is_div   = funct3[2];
    // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed.
    // DIV/REM (funct3[0]=0) are signed on both sides.
    assign signed_a = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign signed_b = is_div ? ~funct3[0] : ~funct3[1];
    assign neg_a    = signed_a & rs1[XLEN-1];
    assign neg_b    = signed_b & rs2[XLEN-1];
    assign mag_a    = neg_a ? -rs1 : rs1;
    assign mag_b    = neg_b ? -rs2 : rs2;
    assign div_zero = is_div & (rs2 == '0);
    assign div_ovf  = is_div & ~funct3[0] & (rs1 == INT_MIN) & (&rs2);

`ifdef MDU_FAST_MUL_EN
    // Sign/zero-extended operands; the low 2*XLEN bits of the product are
    // exactly the signed 33x33 product.
    logic [2*XLEN-1:0] ext_a;
    logic [2*XLEN-1:0] ext_b;
    logic [2*XLEN-1:0] fast_prod;

    assign ext_a     = {{XLEN{neg_a}}, rs1};
    assign ext_b     = {{XLEN{neg_b}}, rs2};
    assign fast_prod = ext_a * ext_b;
`endif

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic              div_ok;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_next;

    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: shift next dividend bit into the remainder, trial-subtract the
    // divisor. The partial remainder is always < divisor, so when the trial
    // succeeds the difference fits back into XLEN bits.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_ok    = (div_shift >= {1'b0, b_q});
    assign div_rem   = div_ok ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
    assign div_next  = {div_rem, acc_q[XLEN-2:0], div_ok};

    // ---------------- sign fix-up and output select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    assign prod_fix = neg_q  ? -acc_q              : acc_q;
    assign quot_fix = neg_q  ? -acc_q[XLEN-1:0]    : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fix_res = prod_fix[XLEN-1:0];
        case (f3_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quot_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;
        ready_d  = ready_q;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // ready_q is still low in the done cycle; it rises here.
                    ready_d = 1'b1;
                    if (start && ready_q) begin
                        ready_d = 1'b0;
                        f3_d    = funct3;
                        b_d     = mag_b;
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        neg_d   = neg_a ^ neg_b;
                        rneg_d  = neg_a;
                        cnt_d   = '0;
                        state_d = RUN;
                        // Special cases preload {rem, quot} with the final
                        // answer and disable sign fix-up.
                        if (div_zero) begin
                            acc_d   = {rs1, {XLEN{1'b1}}};
                            neg_d   = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = FIX;
                        end else if (div_ovf) begin
                            acc_d   = {{XLEN{1'b0}}, INT_MIN};
                            neg_d   = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = FIX;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (!is_div) begin
                            acc_d   = fast_prod;
                            neg_d   = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = FIX;
                        end
`endif
                    end
                end
                RUN: begin
                    acc_d = f3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end
                end
                FIX: begin
                    result_d = fix_res;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = ~ready_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_rv32m_mdu.sv
// Testbench for rv32m_mdu: directed RV32M cases, special divide cases,
// randomized ops against an arithmetic reference model, flush, held start,
// start+flush collision and asynchronous reset mid-operation.
module tb_rv32m_mdu;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b1;
    logic        start  = 1'b0;
    logic        flush  = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1    = 32'd0;
    logic [31:0] rs2    = 32'd0;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int SPEC_LAT = 1;

    rv32m_mdu dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V M-extension semantics using plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int     ia, ib, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = ia / ib;
                return q;
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = ia % ib;
                return q;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 32'h0) return SPEC_LAT;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return SPEC_LAT;
        return DIV_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble the inputs after accept, and observe 36 edges.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int ndone,
                         output int rdy_in_done);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        rs1    = $urandom;
        rs2    = $urandom;
        lat = -1; ndone = 0; rdy_in_done = 0; res = 32'hDEAD_BEEF;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    res = result;
                    if (ready) rdy_in_done = 1;
                end
            end
        end
        $display("op f3=%0d a=%h b=%h -> result=%h lat=%0d dones=%0d", f, a, b, res, lat, ndone);
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #2;
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_errors++;
            $display("FAIL reset: ready=%b busy=%b done=%b result=%h, need 1 0 0 00000000",
                     ready, busy, done, result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_mul();
        logic [2:0]  tf[4] = '{3'd1, 3'd0, 3'd3, 3'd2};
        logic [31:0] ta[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
        logic [31:0] te[4] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat, nd, rd;
        for (int i = 0; i < 4; i++) begin
            do_op(tf[i], ta[i], tb[i], res, lat, nd, rd);
            n_checks++;
            if (res !== te[i]) begin
                n_errors++;
                $display("FAIL mul_result[%0d]: got %h expected %h", i, res, te[i]);
            end
            n_checks++;
            if (lat != MUL_LAT || nd != 1 || rd != 0) begin
                n_errors++;
                $display("FAIL mul_timing[%0d]: lat=%0d dones=%0d ready_in_done=%0d, need lat=%0d dones=1 ready_in_done=0",
                         i, lat, nd, rd, MUL_LAT);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  tf[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] tb[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] te[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int lat, nd, rd;
        for (int i = 0; i < 4; i++) begin
            do_op(tf[i], ta[i], tb[i], res, lat, nd, rd);
            n_checks++;
            if (res !== te[i]) begin
                n_errors++;
                $display("FAIL div_result[%0d]: got %h expected %h", i, res, te[i]);
            end
            n_checks++;
            if (lat != DIV_LAT || nd != 1) begin
                n_errors++;
                $display("FAIL div_timing[%0d]: lat=%0d dones=%0d, need lat=%0d dones=1",
                         i, lat, nd, DIV_LAT);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  tf[6] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
        logic [31:0] ta[6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
        logic [31:0] tb[6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] te[6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        logic [31:0] res;
        int lat, nd, rd;
        for (int i = 0; i < 6; i++) begin
            do_op(tf[i], ta[i], tb[i], res, lat, nd, rd);
            n_checks++;
            if (res !== te[i]) begin
                n_errors++;
                $display("FAIL special_result[%0d]: got %h expected %h", i, res, te[i]);
            end
            n_checks++;
            if (lat != SPEC_LAT || nd != 1) begin
                n_errors++;
                $display("FAIL special_timing[%0d]: lat=%0d dones=%0d, need lat=%0d dones=1",
                         i, lat, nd, SPEC_LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp_res;
        int lat, nd, rd, el;
        for (int i = 0; i < 120; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            exp_res = ref_model(f, a, b);
            el = exp_lat(f, a, b);
            do_op(f, a, b, res, lat, nd, rd);
            n_checks++;
            if (res !== exp_res || lat != el || nd != 1) begin
                n_errors++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h: got %h lat=%0d dones=%0d, need %h lat=%0d dones=1",
                         i, f, a, b, res, lat, nd, exp_res, el);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat, nd, rd, nd2;
        do_op(3'd5, 32'd100, 32'd7, res, lat, nd, rd);
        n_checks++;
        if (res !== 32'd14) begin
            n_errors++;
            $display("FAIL flush_setup: got %h expected %h", res, 32'd14);
        end
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1 = $urandom; rs2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_idle: ready=%b busy=%b done=%b, need 1 0 0", ready, busy, done);
        end
        nd2 = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 if (done) nd2++;
        end
        n_checks++;
        if (nd2 != 0 || result !== 32'd14) begin
            n_errors++;
            $display("FAIL flush_no_done: dones=%0d result=%h, need 0 and %h", nd2, result, 32'd14);
        end
        $display("flush: aborted op, result held at %h", result);
    endtask

    task automatic test_flush_start();
        logic [31:0] held;
        int nd;
        held = result;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1 = 32'd200; rs2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_start_accepted: ready=%b busy=%b, need 1 0", ready, busy);
        end
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        n_checks++;
        if (nd != 0 || result !== held) begin
            n_errors++;
            $display("FAIL flush_start_done: dones=%0d result=%h, need 0 and %h", nd, result, held);
        end
        $display("flush+start: op not accepted, result=%h", result);
    endtask

    task automatic test_start_held();
        logic [31:0] a2, b2, r1, r2;
        int nd, lat, seen_ready;
        a2 = $urandom;
        b2 = 32'($urandom_range(1, 1000));
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk);
        #1;
        funct3 = 3'd7; rs1 = a2; rs2 = b2;   // start stays high
        nd = 0; lat = -1; seen_ready = 0; r1 = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin nd++; lat = k; r1 = result; end
            if (ready) begin seen_ready = 1; break; end
        end
        n_checks++;
        if (nd != 1 || lat != DIV_LAT || r1 !== 32'd14 || seen_ready != 1) begin
            n_errors++;
            $display("FAIL held_first: dones=%0d lat=%0d result=%h ready_seen=%0d, need 1 %0d %h 1",
                     nd, lat, r1, seen_ready, DIV_LAT, 32'd14);
        end
        @(posedge clk);
        #1 start = 1'b0;
        n_checks++;
        if (ready !== 1'b0) begin
            n_errors++;
            $display("FAIL held_accept: ready=%b after held start, need 0", ready);
        end
        nd = 0; lat = -1; r2 = 32'h0;
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            #1 if (done) begin nd++; lat = k; r2 = result; end
        end
        n_checks++;
        if (nd != 1 || lat != DIV_LAT || r2 !== ref_model(3'd7, a2, b2)) begin
            n_errors++;
            $display("FAIL held_second: dones=%0d lat=%0d result=%h, need 1 %0d %h",
                     nd, lat, r2, DIV_LAT, ref_model(3'd7, a2, b2));
        end
        $display("held start: first=%h second=%h", r1, r2);
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int nd, lat, rd;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: ready=%b busy=%b done=%b result=%h, need 1 0 0 00000000",
                     ready, busy, done, result);
        end
        @(negedge clk);
        rstn = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        n_checks++;
        if (nd != 0) begin
            n_errors++;
            $display("FAIL async_reset_no_done: dones=%0d, need 0", nd);
        end
        do_op(3'd0, 32'd12345, 32'd678, res, lat, nd, rd);
        n_checks++;
        if (res !== 32'd8369910 || lat != MUL_LAT || nd != 1) begin
            n_errors++;
            $display("FAIL async_reset_recover: got %h lat=%0d dones=%0d, need %h lat=%0d dones=1",
                     res, lat, nd, 32'd8369910, MUL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_random();
        test_flush();
        test_flush_start();
        test_start_held();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
